mem_write_logger: RTL and testbench

- Downstream observer of the single-cycle processor's data-memory port.
- Captures every store (MemWrite, DataAdr, WriteData) and the current PC into a first-word-fall-through FIFO.
- Drains the FIFO to the verification bench or a trace sink through a valid/ready handshake.
- Lets store streams be checked without probing dmem internals. Counts stores dropped because the FIFO was full.

---
 rtl/memlog_pkg.sv | 16 +
 rtl/mem_write_logger_if.sv | 42 ++++
 rtl/memlog_fifo.sv | 70 +++++++
 rtl/mem_write_logger.sv | 85 ++++++++
 tb/tb_mem_write_logger.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memlog_pkg.sv
// Shared types for the data-memory store logger: the captured entry layout and its width.
// Optional build macro: MEMLOG_TIMESTAMP_EN adds a capture timestamp to every entry.
package memlog_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
`ifdef MEMLOG_TIMESTAMP_EN
    logic [31:0] tstamp;
`endif
  } memlog_entry_t;

  localparam int ENTRY_W = $bits(memlog_entry_t);

endpackage : memlog_pkg

// File: rtl/mem_write_logger_if.sv
// Store-capture and drain signals of the memory write logger, bundled with modports.
// Optional build macro: MEMLOG_TIMESTAMP_EN adds out_time.
interface mem_write_logger_if #(
  parameter int DEPTH = 8,
  parameter int OVF_W = 16
);
  logic                     log_en;
  logic                     MemWrite;
  logic [31:0]              DataAdr;
  logic [31:0]              WriteData;
  logic [31:0]              PCO;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_addr;
  logic [31:0]              out_data;
  logic [31:0]              out_pc;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;
  logic [OVF_W-1:0]         ovf_cnt;
`ifdef MEMLOG_TIMESTAMP_EN
  logic [31:0]              out_time;
`endif

  // Processor side and trace sink together form the master.
  modport master (
    output log_en, MemWrite, DataAdr, WriteData, PCO, out_ready,
    input  out_valid, out_addr, out_data, out_pc, count, full, empty, ovf_cnt
`ifdef MEMLOG_TIMESTAMP_EN
    , input out_time
`endif
  );

  modport slave (
    input  log_en, MemWrite, DataAdr, WriteData, PCO, out_ready,
    output out_valid, out_addr, out_data, out_pc, count, full, empty, ovf_cnt
`ifdef MEMLOG_TIMESTAMP_EN
    , output out_time
`endif
  );

endinterface : mem_write_logger_if

// File: rtl/memlog_fifo.sv
// Generic first-word-fall-through synchronous FIFO; full/empty derive from the occupancy count.
module memlog_fifo #(
  parameter  int WIDTH = 96,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("memlog_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) wptr_d = wptr_q + AW'(1);
    if (rd_en) rptr_d = rptr_q + AW'(1);
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments; only pointers and count are reset,
  // the storage array is not, since empty-gating at the top hides its contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata;
  end

endmodule : memlog_fifo

// File: rtl/mem_write_logger.sv
// Captures processor stores into a FWFT FIFO and drains them over valid/ready; counts drops.
// Optional build macro: MEMLOG_TIMESTAMP_EN adds a free-running cycle stamp per entry (out_time).
module mem_write_logger
  import memlog_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int OVF_W = 16
) (
  input logic              clk,
  input logic              reset,
  mem_write_logger_if.slave lg
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             push, pop, drop;
  logic             full, empty;
  logic [CW-1:0]    count;
  memlog_entry_t    wr_entry, rd_entry, head;
  logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;
`ifdef MEMLOG_TIMESTAMP_EN
  logic [31:0]      ts_q, ts_d;
`endif

  always_comb begin
    push      = lg.log_en & lg.MemWrite;
    pop       = ~empty & lg.out_ready;
    drop      = push & full & ~pop;
    ovf_cnt_d = ovf_cnt_q;
    if (drop && ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + OVF_W'(1);

    wr_entry      = '0;
    wr_entry.addr = lg.DataAdr;
    wr_entry.data = lg.WriteData;
    wr_entry.pc   = lg.PCO;
`ifdef MEMLOG_TIMESTAMP_EN
    wr_entry.tstamp = ts_q;
    ts_d            = ts_q + 32'd1;
`endif
    // Storage is never reset, so the head is forced to zero whenever nothing is queued.
    head = empty ? '0 : rd_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_cnt_q <= '0;
`ifdef MEMLOG_TIMESTAMP_EN
      ts_q      <= '0;
`endif
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
`ifdef MEMLOG_TIMESTAMP_EN
      ts_q      <= ts_d;
`endif
    end
  end

  memlog_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign lg.out_valid = ~empty;
  assign lg.out_addr  = head.addr;
  assign lg.out_data  = head.data;
  assign lg.out_pc    = head.pc;
  assign lg.count     = count;
  assign lg.full      = full;
  assign lg.empty     = empty;
  assign lg.ovf_cnt   = ovf_cnt_q;
`ifdef MEMLOG_TIMESTAMP_EN
  assign lg.out_time  = head.tstamp;
`endif

endmodule : mem_write_logger

// File: tb/tb_mem_write_logger.sv
// Self-checking bench for mem_write_logger against a queue-based model of the store log.
module tb_mem_write_logger;

  localparam int DEPTH = 8;
  localparam int OVF_W = 16;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] ts;
  } m_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] ts;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] ovf;
  } snap_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  m_entry_t    mq[$];
  logic [15:0] m_ovf;
  logic [31:0] m_cyc;

  mem_write_logger_if #(.DEPTH(DEPTH), .OVF_W(OVF_W)) bus ();

  mem_write_logger #(.DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
    .clk   (clk),
    .reset (reset),
    .lg    (bus)
  );

  always #5 clk = ~clk;

  // Model of one clock edge: head leaves if the sink takes it, then the store lands if room.
  task automatic model_edge();
    logic     do_push;
    m_entry_t e;
    do_push = bus.log_en & bus.MemWrite;
    if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
    if (do_push) begin
      if (mq.size() < DEPTH) begin
        e.addr = bus.DataAdr; e.data = bus.WriteData; e.pc = bus.PCO; e.ts = m_cyc;
        mq.push_back(e);
      end else if (m_ovf != 16'hFFFF) begin
        m_ovf = m_ovf + 16'd1;
      end
    end
    m_cyc = m_cyc + 32'd1;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic snap_t exp_snap();
    snap_t s;
    s = '0;
    s.valid = (mq.size() > 0);
    if (mq.size() > 0) begin
      s.addr = mq[0].addr; s.data = mq[0].data; s.pc = mq[0].pc;
`ifdef MEMLOG_TIMESTAMP_EN
      s.ts = mq[0].ts;
`endif
    end
    s.count = 4'(mq.size());
    s.full  = (mq.size() == DEPTH);
    s.empty = (mq.size() == 0);
    s.ovf   = m_ovf;
    return s;
  endfunction

  function automatic snap_t obs_snap();
    snap_t s;
    s = '0;
    s.valid = bus.out_valid; s.addr = bus.out_addr; s.data = bus.out_data; s.pc = bus.out_pc;
`ifdef MEMLOG_TIMESTAMP_EN
    s.ts = bus.out_time;
`endif
    s.count = bus.count; s.full = bus.full; s.empty = bus.empty; s.ovf = bus.ovf_cnt;
    return s;
  endfunction

  task automatic set_store(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] p);
    bus.MemWrite = we; bus.DataAdr = a; bus.WriteData = d; bus.PCO = p;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.log_en = 1'b1; bus.out_ready = 1'b0;
    set_store(1'b0, '0, '0, '0);
    mq.delete(); m_ovf = '0; m_cyc = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    snap_t o, e;
    do_reset();
    o = obs_snap(); e = '0; e.empty = 1'b1;
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_state: got %h want %h", o, e); end
  endtask

  task automatic test_single_store();
    snap_t o, e;
    do_reset();
    set_store(1'b1, 32'h64, 32'd7, 32'h3C);
    cycle();
    set_store(1'b0, '0, '0, '0);
    o = obs_snap(); e = exp_snap();
    checks++;
    if (o !== e) begin errors++; $display("FAIL single_store: got %h want %h", o, e); end
    checks++;
    if ({bus.out_valid, bus.out_addr, bus.out_data, bus.out_pc, bus.count} !==
        {1'b1, 32'h64, 32'd7, 32'h3C, 4'd1}) begin
      errors++; $display("FAIL single_store_fields: got data %h count %0d want 7/1",
                         bus.out_data, bus.count);
    end
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    o = obs_snap(); e = '0; e.empty = 1'b1;
    checks++;
    if (o !== e) begin errors++; $display("FAIL single_pop: got %h want %h", o, e); end
  endtask

  task automatic test_overflow();
    snap_t o, e;
    do_reset();
    for (int i = 1; i <= DEPTH + 3; i++) begin
      set_store(1'b1, 32'h1000 + 32'(4 * i), 32'(i), 32'h200 + 32'(4 * i));
      cycle();
    end
    set_store(1'b0, '0, '0, '0);
    o = obs_snap(); e = exp_snap();
    checks++;
    if (o !== e) begin errors++; $display("FAIL overflow_state: got %h want %h", o, e); end
    checks++;
    if ({bus.full, bus.count, bus.ovf_cnt} !== {1'b1, 4'd8, 16'd3}) begin
      errors++; $display("FAIL overflow_counts: got full=%b count=%0d ovf=%0d want 1/8/3",
                         bus.full, bus.count, bus.ovf_cnt);
    end
    bus.out_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if (bus.out_data !== 32'(i) || bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL drain_order[%0d]: got %h want %h", i, bus.out_data, i);
      end
      cycle();
    end
    bus.out_ready = 1'b0;
    o = obs_snap(); e = exp_snap();
    checks++;
    if (o !== e) begin errors++; $display("FAIL drain_empty: got %h want %h", o, e); end
  endtask

  task automatic test_full_passthrough();
    snap_t o, e;
    logic [15:0] ovf_before;
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      set_store(1'b1, $urandom, $urandom, $urandom);
      cycle();
    end
    ovf_before = bus.ovf_cnt;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_store(1'b1, $urandom, $urandom, $urandom);
      cycle();
      o = obs_snap(); e = exp_snap();
      checks++;
      if (o !== e || bus.count !== 4'd8 || bus.ovf_cnt !== ovf_before) begin
        errors++; $display("FAIL full_passthrough[%0d]: got %h want %h", i, o, e);
      end
    end
    set_store(1'b0, '0, '0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      o = obs_snap(); e = exp_snap();
      checks++;
      if (o !== e) begin errors++; $display("FAIL wrap_drain[%0d]: got %h want %h", i, o, e); end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_log_en_off();
    snap_t o, e;
    do_reset();
    bus.log_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, $urandom, $urandom, $urandom);
      cycle();
      o = obs_snap(); e = '0; e.empty = 1'b1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL log_en_off[%0d]: got %h want %h", i, o, e); end
    end
    set_store(1'b0, '0, '0, '0);
    bus.log_en = 1'b1;
  endtask

  task automatic test_async_reset();
    snap_t o, e;
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      set_store(1'b1, $urandom, $urandom, $urandom);
      cycle();
    end
    set_store(1'b0, '0, '0, '0);
    bus.out_ready = 1'b1;
    repeat (3) cycle();
    bus.out_ready = 1'b0;
    o = obs_snap(); e = exp_snap();
    checks++;
    if (o !== e || bus.count !== 4'd5 || bus.ovf_cnt !== 16'd2) begin
      errors++; $display("FAIL pre_reset_fill: got %h want %h", o, e);
    end
    #2 reset = 1'b1;
    #1;
    o = obs_snap(); e = '0; e.empty = 1'b1;
    checks++;
    if (o !== e) begin errors++; $display("FAIL async_reset: got %h want %h", o, e); end
    @(posedge clk);
    #1 reset = 1'b0;
    mq.delete(); m_ovf = '0; m_cyc = '0;
  endtask

  task automatic test_random();
    snap_t o, e;
    int    mism;
    do_reset();
    mism = 0;
    for (int i = 0; i < 400; i++) begin
      bus.log_en    = ($urandom_range(0, 9) != 0);
      bus.out_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      set_store(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
      cycle();
      o = obs_snap(); e = exp_snap();
      checks++;
      if (o !== e) begin
        errors++;
        if (mism < 10) $display("FAIL random[%0d]: got %h want %h", i, o, e);
        mism++;
      end
    end
    set_store(1'b0, '0, '0, '0);
    bus.out_ready = 1'b0;
  endtask

`ifdef MEMLOG_TIMESTAMP_EN
  task automatic test_timestamp();
    do_reset();
    while (m_cyc < 32'd10) cycle();
    set_store(1'b1, 32'hA0, 32'h11, 32'h40);
    cycle();
    set_store(1'b0, '0, '0, '0);
    while (m_cyc < 32'd13) cycle();
    set_store(1'b1, 32'hA4, 32'h22, 32'h48);
    cycle();
    set_store(1'b0, '0, '0, '0);
    checks++;
    if (bus.out_time !== 32'd10) begin
      errors++; $display("FAIL timestamp_first: got %0d want 10", bus.out_time);
    end
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_time !== 32'd13) begin
      errors++; $display("FAIL timestamp_second: got %0d want 13", bus.out_time);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_store();
    test_overflow();
    test_full_passthrough();
    test_log_en_off();
    test_async_reset();
    test_random();
`ifdef MEMLOG_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_write_logger
